dot_result_fifo: RTL

Result buffer directly downstream of the byte-serial dot-product stage. Captures each 18-bit dot product on the producer's `run` strobe and holds up to `DEPTH` results in a circular FIFO. Delivers them to the consumer over a valid/ready handshake. Tracks occupancy and flags any result lost to a full buffer.

---
 rtl/dot_result_fifo.sv | 90 +++++++++
 1 files changed

// File: rtl/dot_result_fifo.sv
// rtl/dot_result_fifo.sv - circular result FIFO behind the dot-product stage, valid/ready drain.
// Optional DOT_RESULT_SKIP_FIRST_EN drops the first run after reset (stale producer output).
module dot_result_fifo #(
  parameter int DATA_W = 18,
  parameter int DEPTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [DATA_W-1:0]          i_din,
  input  logic                       i_run,
  output logic [DATA_W-1:0]          o_dout,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;

  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;

`ifdef DOT_RESULT_SKIP_FIRST_EN
  logic r_skip;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_skip <= 1'b1;
    end else if (i_run) begin
      r_skip <= 1'b0;
    end
  end

  assign w_push_req = i_run & ~r_skip;
`else
  assign w_push_req = i_run;
`endif

  assign o_valid    = (r_count != '0);
  assign o_full     = (r_count == CNT_FULL);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_dout     = r_mem[r_rd_ptr];

  // A pop on the same edge frees the head slot, so a full FIFO can still accept.
  assign w_pop  = o_valid & i_ready;
  assign w_push = w_push_req & (~o_full | w_pop);
  assign w_drop = w_push_req & o_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
